// File: rtl/part_three_sequencer_pkg.sv
// Shared constants for the part_three sequencer: FSM encoding, settle default
// and settle-counter width.
package part_three_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  localparam int SETTLE_DEFAULT = 1;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/part_three_sequencer_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not served last wins,
// otherwise whichever requester is valid is granted.
module part_three_sequencer_rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last,
  output logic o_gnt_valid,
  output logic o_gnt_id
);

  assign o_gnt_valid = i_valid0 | i_valid1;
  assign o_gnt_id    = (i_valid0 & i_valid1) ? ~i_last : i_valid1;

endmodule

// File: rtl/part_three_sequencer.sv
// Sequencer sharing one external combinational x->y datapath between two
// requesters, one operation in flight, results returned with a requester id.
module part_three_sequencer
  import part_three_sequencer_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [WIDTH-1:0] dp_x,
  input  logic [WIDTH-1:0] dp_y,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  input  logic             resp_ready
);

  state_t           r_state;
  logic [WIDTH-1:0] r_dp_x;
  logic [WIDTH-1:0] r_resp_data;
  logic             r_resp_valid;
  logic             r_resp_id;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;

  logic             w_gnt_valid;
  logic             w_gnt_id;
  logic             w_accept;
  logic [WIDTH-1:0] w_operand;

  part_three_sequencer_rr_arb2 u_arb (
    .i_valid0    (req0_valid),
    .i_valid1    (req1_valid),
    .i_last      (r_last),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  // Ready is combinational so a valid requester transfers in the same IDLE cycle.
  assign w_accept   = (r_state == ST_IDLE) && !rst && w_gnt_valid;
  assign req0_ready = w_accept && !w_gnt_id;
  assign req1_ready = w_accept &&  w_gnt_id;
  assign w_operand  = w_gnt_id ? req1_data : req0_data;

  assign dp_x       = r_dp_x;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_dp_x       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= 1'b0;
      r_cnt        <= '0;
      r_last       <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dp_x  <= w_operand;
            r_last  <= w_gnt_id;
            r_cnt   <= '0;
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == CNT_W'(SETTLE - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_CAPTURE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          r_resp_data  <= dp_y;
          r_resp_id    <= r_last;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_part_three_sequencer.sv
// Directed bench for part_three_sequencer with a nibble-swap-xor datapath model;
// one instance at SETTLE=1 and one at SETTLE=3.
module tb_part_three_sequencer;
  import part_three_sequencer_pkg::*;

  logic       clk;
  logic       rst, req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data, dp_x, dp_y, resp_data;
  logic       resp_valid, resp_id, resp_ready;

  logic       s3_rst, s3_req0_valid, s3_req1_valid, s3_req0_ready, s3_req1_ready;
  logic [7:0] s3_req0_data, s3_req1_data, s3_dp_x, s3_dp_y, s3_resp_data;
  logic       s3_resp_valid, s3_resp_id, s3_resp_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // External datapath: swap nibbles then xor 8'h3C.
  function automatic logic [7:0] part_three(input logic [7:0] x);
    return {x[3:0], x[7:4]} ^ 8'h3C;
  endfunction

  assign dp_y    = part_three(dp_x);
  assign s3_dp_y = part_three(s3_dp_x);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  part_three_sequencer #(.SETTLE(1), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .dp_x(dp_x), .dp_y(dp_y),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
    .resp_ready(resp_ready)
  );

  part_three_sequencer #(.SETTLE(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst(s3_rst),
    .req0_valid(s3_req0_valid), .req0_data(s3_req0_data), .req0_ready(s3_req0_ready),
    .req1_valid(s3_req1_valid), .req1_data(s3_req1_data), .req1_ready(s3_req1_ready),
    .dp_x(s3_dp_x), .dp_y(s3_dp_y),
    .resp_valid(s3_resp_valid), .resp_data(s3_resp_data), .resp_id(s3_resp_id),
    .resp_ready(s3_resp_ready)
  );

  // Counts rising edges after the accept edge until resp_valid is seen; -1 on timeout.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; s3_rst = 1'b1;
    req0_valid = 1'b1; req0_data = 8'hA8; req1_valid = 1'b0; req1_data = 8'h00;
    resp_ready = 1'b0;
    s3_req0_valid = 1'b0; s3_req0_data = 8'h00; s3_req1_valid = 1'b0;
    s3_req1_data = 8'h00; s3_resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dp_x !== 8'h00) begin n_bad++; $display("FAIL reset_dp_x got %h exp 00", dp_x); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    n_cmp++; if (resp_data !== 8'h00) begin n_bad++; $display("FAIL reset_resp_data got %h exp 00", resp_data); end
    n_cmp++; if (resp_id !== 1'b0) begin n_bad++; $display("FAIL reset_resp_id got %b exp 0", resp_id); end
    n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req0_ready got %b exp 0", req0_ready); end
    n_cmp++; if (s3_dp_x !== 8'h00) begin n_bad++; $display("FAIL reset_s3_dp_x got %h exp 00", s3_dp_x); end
  endtask

  task automatic test_single;
    int lat;
    rst = 1'b0; req0_valid = 1'b1; req0_data = 8'hA8; resp_ready = 1'b1;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL single_req0_ready got %b exp 1", req0_ready); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL single_req1_ready got %b exp 0", req1_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n_cmp++; if (dp_x !== 8'hA8) begin n_bad++; $display("FAIL single_dp_x got %h exp a8", dp_x); end
    n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL single_busy_ready got %b exp 0", req0_ready); end
    wait_resp(lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL single_latency got %0d exp 2", lat); end
    n_cmp++; if (resp_data !== 8'hB6) begin n_bad++; $display("FAIL single_resp_data got %h exp b6", resp_data); end
    n_cmp++; if (resp_id !== 1'b0) begin n_bad++; $display("FAIL single_resp_id got %b exp 0", resp_id); end
    @(posedge clk); #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_resp_drop got %b exp 0", resp_valid); end
    n_cmp++; if (dp_x !== 8'hA8) begin n_bad++; $display("FAIL single_dp_x_hold got %h exp a8", dp_x); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_data;
    int got;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h11; req1_valid = 1'b1; req1_data = 8'h22;
    resp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        exp_data = (got % 2 == 0) ? 8'h2D : 8'h1E;
        n_cmp++; if (resp_id !== 1'(got % 2)) begin n_bad++; $display("FAIL b2b_id[%0d] got %b exp %0d", got, resp_id, got % 2); end
        n_cmp++; if (resp_data !== exp_data) begin n_bad++; $display("FAIL b2b_data[%0d] got %h exp %h", got, resp_data, exp_data); end
        got++;
        if (got == 4) begin
          req0_valid = 1'b0; req1_valid = 1'b0;
          break;
        end
      end
    end
    n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL b2b_count got %0d exp 4", got); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    int lat;
    @(negedge clk);
    req1_valid = 1'b1; req1_data = 8'h5C; resp_ready = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_resp(lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL bp_latency got %0d exp 2", lat); end
    req0_valid = 1'b1; req0_data = 8'h01; req1_valid = 1'b1; req1_data = 8'h02;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %b exp 1", c, resp_valid); end
      n_cmp++; if (resp_data !== 8'hF9) begin n_bad++; $display("FAIL bp_data[%0d] got %h exp f9", c, resp_data); end
      n_cmp++; if (resp_id !== 1'b1) begin n_bad++; $display("FAIL bp_id[%0d] got %b exp 1", c, resp_id); end
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL bp_ready[%0d] got %b exp 00", c, {req0_ready, req1_ready}); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got %b exp 0", resp_valid); end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h33;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n_cmp++; if (dp_x !== 8'h33) begin n_bad++; $display("FAIL mid_dp_x got %h exp 33", dp_x); end
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_ready got %b exp 00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_resp_valid got %b exp 0", resp_valid); end
    n_cmp++; if (dp_x !== 8'h00) begin n_bad++; $display("FAIL mid_dp_x_reset got %h exp 00", dp_x); end
    n_cmp++; if ({resp_data, resp_id} !== 9'h000) begin n_bad++; $display("FAIL mid_resp_reset got %h exp 000", {resp_data, resp_id}); end
    @(negedge clk);
    rst = 1'b0; req0_data = 8'h44; req1_data = 8'h55;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL mid_first_grant got %b exp 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mid_latency got %0d exp 2", lat); end
    n_cmp++; if ({resp_data, resp_id} !== {8'h78, 1'b0}) begin n_bad++; $display("FAIL mid_resp got %h/%b exp 78/0", resp_data, resp_id); end
    @(posedge clk); #1;
    n_cmp++; if (dp_x !== 8'h44) begin n_bad++; $display("FAIL mid_dp_x_hold got %h exp 44", dp_x); end
  endtask

  task automatic test_req1_only;
    int got, acc;
    @(negedge clk);
    req1_valid = 1'b1; req1_data = 8'h66; resp_ready = 1'b1;
    got = 0; acc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req1_ready) acc++;
      if (resp_valid) begin
        n_cmp++; if ({resp_id, resp_data} !== {1'b1, 8'h5A}) begin n_bad++; $display("FAIL r1_resp[%0d] got %b/%h exp 1/5a", got, resp_id, resp_data); end
        got++;
        if (got == 3) begin
          req1_valid = 1'b0;
          break;
        end
      end
    end
    n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL r1_count got %0d exp 3", got); end
    n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL r1_accepts got %0d exp 2", acc); end
    req1_valid = 1'b0;
  endtask

  task automatic test_settle3;
    @(negedge clk);
    s3_rst = 1'b0; s3_req0_valid = 1'b1; s3_req0_data = 8'hA8; s3_resp_ready = 1'b1;
    #1;
    n_cmp++; if (s3_req0_ready !== 1'b1) begin n_bad++; $display("FAIL s3_ready got %b exp 1", s3_req0_ready); end
    @(posedge clk); #1;
    s3_req0_valid = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      n_cmp++; if (s3_dp_x !== 8'hA8) begin n_bad++; $display("FAIL s3_dp_x[%0d] got %h exp a8", e, s3_dp_x); end
      n_cmp++; if (s3_resp_valid !== 1'b0) begin n_bad++; $display("FAIL s3_early_valid[%0d] got %b exp 0", e, s3_resp_valid); end
    end
    @(posedge clk); #1;
    n_cmp++; if (s3_resp_valid !== 1'b1) begin n_bad++; $display("FAIL s3_valid_at_4 got %b exp 1", s3_resp_valid); end
    n_cmp++; if ({s3_resp_data, s3_resp_id} !== {8'hB6, 1'b0}) begin n_bad++; $display("FAIL s3_resp got %h/%b exp b6/0", s3_resp_data, s3_resp_id); end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_req1_only();
    test_settle3();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/part_three_sequencer.md
PART_THREE_SEQUENCER -- requirements
Module: part_three_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, giving cycles (1..15) that dp_x is held before dp_y is sampled.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the datapath operand/result width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 offers an operand.
REQ-006 req0_data  input  WIDTH  requester 0 operand.
REQ-007 req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-008 req1_valid  input  1  requester 1 offers an operand.
REQ-009 req1_data  input  WIDTH  requester 1 operand.
REQ-010 req1_ready  output  1  requester 1 operand accepted this cycle.
REQ-011 dp_x  output  WIDTH  operand driven to the shared combinational x->y datapath.
REQ-012 dp_y  input  WIDTH  datapath result.
REQ-013 resp_valid  output  1  result available.
REQ-014 resp_data  output  WIDTH  captured dp_y.
REQ-015 resp_id  output  1  requester index owning resp_data.
REQ-016 resp_ready  input  1  consumer accepts result.

Function
REQ-017 The block SHALL implement FSM states IDLE, DRIVE, CAPTURE, RESPOND.
REQ-018 In IDLE, a transfer SHALL occur when the granted requester has valid high; req_ready is asserted combinationally only for the granted requester and only in IDLE.
REQ-019 Grant SHALL be round-robin: with both valid, grant the requester not served last; with one valid, grant it.
REQ-020 On transfer, the operand SHALL be registered into dp_x, the id registered, last-served pointer updated, and the state SHALL move to DRIVE.
REQ-021 DRIVE SHALL count SETTLE cycles with a 4-bit counter while dp_x stays stable, then move to CAPTURE.
REQ-022 CAPTURE SHALL register dp_y into resp_data, set resp_valid, and move to RESPOND; total latency from accept edge to resp_valid high is SETTLE+1 cycles.
REQ-023 In RESPOND, resp_valid SHALL stay high and resp_data/resp_id stable until resp_ready is high; on that cycle resp_valid falls next edge and state returns to IDLE.
REQ-024 No new operand SHALL be accepted outside IDLE (one operation in flight; back-pressure via req_ready low).
REQ-025 dp_x SHALL hold its last operand after completion (no return to zero).
REQ-026 A requester dropping valid while not granted SHALL not disturb the pointer.
REQ-027 resp_ready asserted before resp_valid SHALL have no effect.

Reset
REQ-028 With rst high at a rising edge: state IDLE, dp_x 0, resp_valid 0, resp_data 0, resp_id 0, settle counter 0, last-served pointer 1 (so requester 0 wins first tie).
REQ-029 Reset mid-operation SHALL abandon the operation without emitting a response; req_ready SHALL be 0 while rst is high.

Structure
REQ-030 State encoding (2-bit) and SETTLE default SHALL live in a shared constants include used by this block and its bench.
REQ-031 A sub-module rr_arb2 (2-way round-robin grant, pointer input, grant output) is natural; the FSM stays in the top.
REQ-032 The datapath partThree SHALL be instantiated outside this block and wired via dp_x/dp_y.

Verification
REQ-033 Single request: req0 data 8'hA8, SETTLE=1, resp_ready high -> resp_valid 2 cycles after accept, resp_data = datapath(8'hA8), resp_id 0.
REQ-034 Both valid continuously, data 8'h11/8'h22 -> responses alternate id 0,1,0,1 starting with 0.
REQ-035 resp_ready low for 5 cycles -> resp_valid/resp_data held, both req_ready low throughout.
REQ-036 SETTLE=3 -> dp_x stable for 3 cycles, resp_valid exactly 4 cycles after accept.
REQ-037 rst asserted during DRIVE -> no resp_valid, outputs at reset values next cycle, next request granted to requester 0.
REQ-038 Only req1 valid repeatedly -> req1 served every operation, no idle grant to req0.
